irq_scheduler: RTL and testbench
================================

Name: irq_scheduler

Overview:
Interrupt controller that shares the CPU's single external `interrupt` input among N_SRC peripheral requesters. Each requester's rising edge latches a pending bit. Unmasked pending requests are arbitrated, and the winner drives `irq_out` high for a fixed HOLD_CYCLES pulse. The block then waits for software end-of-interrupt (EOI). It sits on the system bridge as a 4-word MMIO device next to the timers; `irq_out` feeds the CPU `interrupt` pin.

Parameters:
N_SRC, 6, number of interrupt requesters (1..8)
ID_W, 3, width of source index; must satisfy 2^ID_W >= N_SRC
HOLD_CYCLES, 6, cycles `irq_out` stays high per grant (>=1; 0 is illegal)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
src_req  input  N_SRC  level request lines; rising edge = new event
bus_we  input  1  register write strobe
bus_addr  input  4  byte offset; only [3:2] decoded
bus_wdata  input  32  write data
bus_rdata  output  32  combinational read data
irq_out  output  1  interrupt to CPU
irq_id  output  ID_W  index of source currently in service
in_service  output  1  high from grant until EOI

Behaviour:
- Registers (offset, function):
  - 0x0 MASK: RW, bits [N_SRC-1:0]; 1 = enabled; reset 0.
  - 0x4 PENDING: read returns pending; write-1-to-clear.
  - 0x8 STATUS: read-only; {in_service at bit 31, zeros, irq_id in [ID_W-1:0]}.
  - 0xC EOI: any write completes service; reads as 0.
  - Unused read bits are 0.
- Edge detect:
  - prev_req is registered each cycle; reset value 0.
  - A cycle with src_req[i] & ~prev_req[i] sets pending[i] at the next edge.
  - Level-held requests do not re-trigger.
- Pending set/clear collision: if a set (new edge) and a clear (W1C or EOI) hit the same bit in the same cycle, the set wins.
- FSM states: IDLE, ASSERT, WAIT_EOI.
  - IDLE: if (pending & MASK) != 0, select a winner, latch irq_id, set in_service=1, load counter=HOLD_CYCLES-1, go to ASSERT. irq_out rises on the same edge as the state change.
  - ASSERT: irq_out=1. Decrement the counter each cycle. When the counter is 0, the next edge goes to WAIT_EOI with irq_out=0. irq_out is therefore high for exactly HOLD_CYCLES cycles.
  - WAIT_EOI: irq_out=0. A write to EOI clears pending[irq_id] (subject to the set-wins rule), clears in_service, and returns to IDLE.
  - EOI written during ASSERT is ignored; the pulse always completes.
- Arbitration: fixed priority, lowest index wins (default build). Arbitration happens only in IDLE, so the earliest next grant is the cycle after EOI.
- MASK or PENDING changes during ASSERT/WAIT_EOI do not abort the current service. Clearing pending[irq_id] via W1C while in service is permitted, and EOI is still required.
- Reset values:
  - irq_out=0, in_service=0, irq_id=0
  - MASK=0, pending=0, prev_req=0
  - state=IDLE, counter=0
- Reset asserted mid-pulse forces irq_out=0 at the next edge and discards all pending events.
- Writes to undecoded offsets have no effect.

Optional Feature:
IRQ_SCHED_ROUND_ROBIN_EN
- Defined: round-robin arbitration. A last_grant register (reset N_SRC-1) is updated on each grant. Search starts at last_grant+1 modulo N_SRC.
- Undefined: fixed lowest-index priority and no last_grant register.
- All other behaviour is identical.

Test Plan:
1. Single event: after reset, write MASK=0x01, pulse src_req[0] 0→1 → PENDING=0x01. irq_out is high for exactly 6 cycles with irq_id=0, then low. STATUS=0x80000000. Writing EOI → PENDING=0, in_service=0.
2. Masked source: MASK=0x00, edge on src_req[3] → PENDING=0x08, irq_out stays 0. Then write MASK=0x08 → grant with irq_id=3 within 2 cycles.
3. Priority and serialization: MASK=0x3F, simultaneous edges on src_req[5] and src_req[2] → first grant irq_id=2. irq_out stays 0 until EOI. After EOI, a second 6-cycle pulse occurs with irq_id=5. With IRQ_SCHED_ROUND_ROBIN_EN and last_grant=2, a later simultaneous 2/5 event grants 5 first.
4. Collision: during WAIT_EOI for source 1, a new edge on src_req[1] arrives in the same cycle as the EOI write → pending[1] remains 1, and source 1 is re-granted immediately.
5. Early EOI and reset: EOI written in cycle 3 of ASSERT → irq_out still high for all 6 cycles and the FSM enters WAIT_EOI. Then reset asserted in cycle 2 of a new pulse → irq_out=0, PENDING=0, MASK=0 the next cycle.
6. Level hold: src_req[4] held high for 50 cycles after one EOI → no second pending set and no further irq_out.

Source files
------------

// File: rtl/irq_scheduler.sv
// -----------------------------------------------------------------------------
// irq_scheduler
//
// Shares the CPU's single interrupt pin among N_SRC requesters. A rising edge
// on src_req[i] latches pending[i]. Unmasked pending requests are arbitrated
// while idle. The winner gets a HOLD_CYCLES-long pulse on irq_out, and the
// block then waits for software to write EOI before it arbitrates again.
//
// Optional build macro:
//   IRQ_SCHED_ROUND_ROBIN_EN - round-robin arbitration starting after the last
//                              grant. Default build: fixed priority, where the
//                              lowest index wins.
//
// MMIO map (byte offset, only bus_addr[3:2] decoded):
//   0x0 MASK    RW   [N_SRC-1:0], 1 = enabled
//   0x4 PENDING R/W1C
//   0x8 STATUS  RO   {in_service, 0..., irq_id}
//   0xC EOI     WO   any write ends service; reads 0
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high, clears all state
//   src_req    level request lines, rising edge = new event
//   bus_we     register write strobe
//   bus_addr   byte offset
//   bus_wdata  write data
//   bus_rdata  combinational read data
//   irq_out    interrupt to CPU
//   irq_id     index of the source in service
//   in_service high from grant until EOI
// -----------------------------------------------------------------------------
module irq_scheduler #(
  parameter int N_SRC       = 6,
  parameter int ID_W        = 3,
  parameter int HOLD_CYCLES = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_req,
  input  logic             bus_we,
  input  logic [3:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             irq_out,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_WAIT_EOI = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ID_W-1:0]  r_irq_id, w_id_nxt;
  logic             r_in_service, w_insvc_nxt;
  logic             r_irq_out, w_irq_nxt;
  logic [N_SRC-1:0] r_mask, r_pending, r_prev_req;

  logic             w_wr_mask, w_wr_pend, w_wr_eoi;
  logic [N_SRC-1:0] w_set, w_w1c, w_eoi_clr, w_req;
  logic [ID_W-1:0]  w_win_id;
  logic             w_grant;

  // Address decode is on bits [3:2]; the byte lanes and upper data bits are unused.
  logic w_unused_ok;
  assign w_unused_ok = ^{bus_addr[1:0], bus_wdata[31:N_SRC]};

  assign w_wr_mask = bus_we && (bus_addr[3:2] == 2'd0);
  assign w_wr_pend = bus_we && (bus_addr[3:2] == 2'd1);
  assign w_wr_eoi  = bus_we && (bus_addr[3:2] == 2'd3);

  assign w_set     = src_req & ~r_prev_req;
  assign w_w1c     = w_wr_pend ? bus_wdata[N_SRC-1:0] : '0;
  // EOI only counts in WAIT_EOI; an early EOI during the pulse is dropped.
  assign w_eoi_clr = (w_wr_eoi && (r_state == ST_WAIT_EOI)) ? (N_SRC'(1) << r_irq_id) : '0;
  assign w_req     = r_pending & r_mask;

`ifdef IRQ_SCHED_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_last_grant;

  // Search begins one past the previous winner and wraps modulo N_SRC.
  always_comb begin
    logic             found;
    logic [N_SRC-1:0] rot;
    int               idx;
    found    = 1'b0;
    w_win_id = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(r_last_grant) + 1 + k) % N_SRC;
      rot = w_req >> idx;
      if (!found && rot[0]) begin
        found    = 1'b1;
        w_win_id = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= ID_W'(N_SRC - 1);
    end else if (w_grant) begin
      r_last_grant <= w_win_id;
    end
  end
`else
  // Scan from the top so that the lowest set index is the last one written.
  always_comb begin
    logic [N_SRC-1:0] rot;
    w_win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      rot = w_req >> i;
      if (rot[0]) w_win_id = ID_W'(i);
    end
  end
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_id_nxt    = r_irq_id;
    w_insvc_nxt = r_in_service;
    w_irq_nxt   = 1'b0;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
          w_id_nxt    = w_win_id;
          w_insvc_nxt = 1'b1;
          w_irq_nxt   = 1'b1;
        end
      end
      ST_ASSERT: begin
        // The count starts at HOLD_CYCLES-1, so the pulse lasts HOLD_CYCLES cycles.
        if (r_cnt == '0) begin
          w_state_nxt = ST_WAIT_EOI;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          w_irq_nxt = 1'b1;
        end
      end
      ST_WAIT_EOI: begin
        if (w_wr_eoi) begin
          w_state_nxt = ST_IDLE;
          w_insvc_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_irq_id     <= '0;
      r_in_service <= 1'b0;
      r_irq_out    <= 1'b0;
      r_mask       <= '0;
      r_pending    <= '0;
      r_prev_req   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_irq_id     <= w_id_nxt;
      r_in_service <= w_insvc_nxt;
      r_irq_out    <= w_irq_nxt;
      r_prev_req   <= src_req;
      if (w_wr_mask) r_mask <= bus_wdata[N_SRC-1:0];
      // The OR with w_set comes last, so a new edge beats a same-cycle clear.
      r_pending    <= (r_pending & ~(w_w1c | w_eoi_clr)) | w_set;
    end
  end

  always_comb begin
    bus_rdata = '0;
    case (bus_addr[3:2])
      2'd0: bus_rdata[N_SRC-1:0] = r_mask;
      2'd1: bus_rdata[N_SRC-1:0] = r_pending;
      2'd2: begin
        bus_rdata[31]     = r_in_service;
        bus_rdata[ID_W-1:0] = r_irq_id;
      end
      default: bus_rdata = '0;
    endcase
  end

  assign irq_out    = r_irq_out;
  assign irq_id     = r_irq_id;
  assign in_service = r_in_service;

endmodule

// File: tb/tb_irq_scheduler.sv
// -----------------------------------------------------------------------------
// tb_irq_scheduler
//
// Self-checking bench for irq_scheduler with default parameters (6 sources,
// 6-cycle pulse). A vector table covers the basic single-event and masking
// flows. Hand-written sequences cover priority, the EOI/edge collision, early
// EOI, reset during a pulse, level hold and W1C.
// -----------------------------------------------------------------------------
module tb_irq_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src_req;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        irq_out;
  logic [2:0]  irq_id;
  logic        in_service;

  int n_checks = 0;
  int n_fail   = 0;

  irq_scheduler #(.N_SRC(6), .ID_W(3), .HOLD_CYCLES(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_req    (src_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .irq_out    (irq_out),
    .irq_id     (irq_id),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  src;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  rd_addr;
    logic [31:0] exp_rdata;
    logic        exp_irq;
    logic        exp_insvc;
    logic [2:0]  exp_id;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] data);
    bus_we   = 1'b0;
    bus_addr = addr;
    #1;
    data = bus_rdata;
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    bus_we    = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    step();
    bus_we    = 1'b0;
    bus_wdata = '0;
  endtask

  // Steps until irq_out is high; n = cycles waited. An expired budget shows up as a failed check.
  task automatic wait_irq(input string name, output int n);
    n = 0;
    while (irq_out !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({name, "_irq_seen"}, {31'b0, irq_out}, 32'd1);
  endtask

  // Counts consecutive high observations of irq_out starting at the current one.
  task automatic pulse_len(output int n);
    n = 0;
    while (irq_out === 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int          n;
    int          hits;
    logic [2:0]  exp_first, exp_second;

    // src, we, addr, wdata, rd_addr, exp_rdata, irq, insvc, id, name
    vecs[0]  = '{6'h00, 1'b1, 4'h0, 32'h01, 4'h4, 32'h0,        1'b0, 1'b0, 3'd0, "t1_mask"};
    vecs[1]  = '{6'h01, 1'b0, 4'h0, 32'h00, 4'h4, 32'h1,        1'b0, 1'b0, 3'd0, "t1_pend"};
    vecs[2]  = '{6'h01, 1'b0, 4'h0, 32'h00, 4'h8, 32'h80000000, 1'b1, 1'b1, 3'd0, "t1_grant"};
    vecs[3]  = '{6'h01, 1'b0, 4'h0, 32'h00, 4'h8, 32'h80000000, 1'b1, 1'b1, 3'd0, "t1_hold2"};
    vecs[4]  = '{6'h01, 1'b0, 4'h0, 32'h00, 4'h8, 32'h80000000, 1'b1, 1'b1, 3'd0, "t1_hold3"};
    vecs[5]  = '{6'h01, 1'b0, 4'h0, 32'h00, 4'h8, 32'h80000000, 1'b1, 1'b1, 3'd0, "t1_hold4"};
    vecs[6]  = '{6'h01, 1'b0, 4'h0, 32'h00, 4'h8, 32'h80000000, 1'b1, 1'b1, 3'd0, "t1_hold5"};
    vecs[7]  = '{6'h01, 1'b0, 4'h0, 32'h00, 4'h8, 32'h80000000, 1'b1, 1'b1, 3'd0, "t1_hold6"};
    vecs[8]  = '{6'h01, 1'b0, 4'h0, 32'h00, 4'h4, 32'h1,        1'b0, 1'b1, 3'd0, "t1_wait"};
    vecs[9]  = '{6'h01, 1'b1, 4'hC, 32'h00, 4'h4, 32'h0,        1'b0, 1'b0, 3'd0, "t1_eoi"};
    vecs[10] = '{6'h00, 1'b1, 4'h0, 32'h00, 4'h0, 32'h0,        1'b0, 1'b0, 3'd0, "t2_mask0"};
    vecs[11] = '{6'h08, 1'b0, 4'h0, 32'h00, 4'h4, 32'h8,        1'b0, 1'b0, 3'd0, "t2_pend"};
    vecs[12] = '{6'h08, 1'b0, 4'h0, 32'h00, 4'hC, 32'h0,        1'b0, 1'b0, 3'd0, "t2_masked"};
    vecs[13] = '{6'h08, 1'b1, 4'h0, 32'h08, 4'h8, 32'h0,        1'b0, 1'b0, 3'd0, "t2_unmask"};
    vecs[14] = '{6'h08, 1'b0, 4'h0, 32'h00, 4'h8, 32'h80000003, 1'b1, 1'b1, 3'd3, "t2_grant"};

    reset     = 1'b1;
    src_req   = '0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check("rst_irq", {31'b0, irq_out}, 32'd0);
    check("rst_insvc", {31'b0, in_service}, 32'd0);
    check("rst_id", {29'b0, irq_id}, 32'd0);
    rd(4'h0, r); check("rst_mask", r, 32'h0);
    rd(4'h4, r); check("rst_pend", r, 32'h0);
    rd(4'h8, r); check("rst_status", r, 32'h0);

    // Single event and masked source from the vector table
    for (int i = 0; i < 15; i++) begin
      src_req   = vecs[i].src;
      bus_we    = vecs[i].we;
      bus_addr  = vecs[i].addr;
      bus_wdata = vecs[i].wdata;
      step();
      bus_we    = 1'b0;
      bus_wdata = '0;
      rd(vecs[i].rd_addr, r);
      check($sformatf("%s_rdata", vecs[i].name), r, vecs[i].exp_rdata);
      check($sformatf("%s_irq", vecs[i].name), {31'b0, irq_out}, {31'b0, vecs[i].exp_irq});
      check($sformatf("%s_insvc", vecs[i].name), {31'b0, in_service}, {31'b0, vecs[i].exp_insvc});
      check($sformatf("%s_id", vecs[i].name), {29'b0, irq_id}, {29'b0, vecs[i].exp_id});
    end
    pulse_len(n);
    check("t2_pulse_len", n, 6);
    bus_write(4'hC, 32'h0);
    check("t2_eoi_insvc", {31'b0, in_service}, 32'd0);

    // Priority and serialization: sources 2 and 5 together
    src_req = 6'h00;
    bus_write(4'h0, 32'h3F);
    src_req = 6'h24;
    step();
    rd(4'h4, r); check("t3_pend", r, 32'h24);
    wait_irq("t3_first", n);
    check("t3_first_wait", n, 1);
    check("t3_first_id", {29'b0, irq_id}, 32'd2);
    pulse_len(n);
    check("t3_first_len", n, 6);
    hits = 0;
    repeat (5) begin
      step();
      if (irq_out !== 1'b0) hits++;
    end
    check("t3_no_irq_before_eoi", hits, 0);
    check("t3_wait_insvc", {31'b0, in_service}, 32'd1);
    bus_write(4'hC, 32'h0);
    check("t3_eoi_insvc", {31'b0, in_service}, 32'd0);
    wait_irq("t3_second", n);
    check("t3_second_wait", n, 1);
    check("t3_second_id", {29'b0, irq_id}, 32'd5);
    pulse_len(n);
    check("t3_second_len", n, 6);
    bus_write(4'hC, 32'h0);

    // Grant source 2 alone, then a simultaneous 2/5 event
    src_req = 6'h00;
    step();
    src_req = 6'h04;
    wait_irq("t3_solo", n);
    check("t3_solo_id", {29'b0, irq_id}, 32'd2);
    pulse_len(n);
    bus_write(4'hC, 32'h0);
    src_req = 6'h00;
    step();
    src_req = 6'h24;
`ifdef IRQ_SCHED_ROUND_ROBIN_EN
    exp_first  = 3'd5;
    exp_second = 3'd2;
`else
    exp_first  = 3'd2;
    exp_second = 3'd5;
`endif
    wait_irq("t3_arb_a", n);
    check("t3_arb_a_id", {29'b0, irq_id}, {29'b0, exp_first});
    pulse_len(n);
    bus_write(4'hC, 32'h0);
    wait_irq("t3_arb_b", n);
    check("t3_arb_b_id", {29'b0, irq_id}, {29'b0, exp_second});
    pulse_len(n);
    bus_write(4'hC, 32'h0);

    // Collision: a new edge on source 1 in the same cycle as its EOI
    src_req = 6'h00;
    step();
    src_req = 6'h02;
    wait_irq("t4", n);
    check("t4_id", {29'b0, irq_id}, 32'd1);
    src_req = 6'h00;
    pulse_len(n);
    check("t4_len", n, 6);
    src_req = 6'h02;
    bus_write(4'hC, 32'h0);
    check("t4_eoi_insvc", {31'b0, in_service}, 32'd0);
    rd(4'h4, r); check("t4_pend_kept", r, 32'h02);
    step();
    check("t4_regrant_irq", {31'b0, irq_out}, 32'd1);
    check("t4_regrant_id", {29'b0, irq_id}, 32'd1);
    pulse_len(n);
    bus_write(4'hC, 32'h0);
    rd(4'h4, r); check("t4_pend_clr", r, 32'h0);

    // Early EOI written in cycle 3 of the pulse
    src_req = 6'h03;
    wait_irq("t5", n);
    check("t5_id", {29'b0, irq_id}, 32'd0);
    step();
    step();
    bus_write(4'hC, 32'h0);
    pulse_len(n);
    check("t5_remaining_len", n, 3);
    check("t5_wait_insvc", {31'b0, in_service}, 32'd1);
    rd(4'h8, r); check("t5_status", r, 32'h80000000);
    bus_write(4'hC, 32'h0);
    check("t5_eoi_insvc", {31'b0, in_service}, 32'd0);

    // Reset in cycle 2 of a pulse, with another source pending
    src_req = 6'h27;
    wait_irq("t5_rst", n);
    check("t5_rst_id", {29'b0, irq_id}, 32'd2);
    step();
    reset = 1'b1;
    step();
    check("t5_rst_irq", {31'b0, irq_out}, 32'd0);
    check("t5_rst_insvc", {31'b0, in_service}, 32'd0);
    rd(4'h4, r); check("t5_rst_pend", r, 32'h0);
    rd(4'h0, r); check("t5_rst_mask", r, 32'h0);
    src_req = 6'h00;
    step();
    reset = 1'b0;

    // Level hold on source 4
    bus_write(4'h0, 32'h10);
    src_req = 6'h10;
    wait_irq("t6", n);
    check("t6_id", {29'b0, irq_id}, 32'd4);
    pulse_len(n);
    check("t6_len", n, 6);
    bus_write(4'hC, 32'h0);
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (irq_out !== 1'b0) hits++;
    end
    check("t6_no_retrigger", hits, 0);
    rd(4'h4, r); check("t6_pend", r, 32'h0);
    check("t6_insvc", {31'b0, in_service}, 32'd0);

    // W1C, and an edge that beats a same-cycle W1C
    bus_write(4'h0, 32'h0);
    src_req = 6'h18;
    step();
    rd(4'h4, r); check("w1c_set", r, 32'h08);
    bus_write(4'h4, 32'h08);
    rd(4'h4, r); check("w1c_clear", r, 32'h0);
    src_req = 6'h10;
    step();
    src_req = 6'h18;
    bus_write(4'h4, 32'h08);
    rd(4'h4, r); check("w1c_set_wins", r, 32'h08);
    check("w1c_masked_irq", {31'b0, irq_out}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
